// File: rtl/lsu_split.sv
// RV32I load/store unit: aligns, extends and splits word-crossing accesses into two dmem words.
// Define LSU_MISALIGN_TRAP_EN to reject word-crossing accesses with resp_err instead of splitting.
module lsu_split #(
    parameter int unsigned DMEM_BYTES = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    input  logic        req_store,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dwe,
    input  logic [31:0] drdata
);
    typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

    state_e      r_state;
    logic [31:0] r_wdata, r_lo, r_daddr, r_dwdata, r_resp_rdata;
    logic [2:0]  r_funct3;
    logic        r_store;
    logic [1:0]  r_o;
    logic [7:0]  r_span;
    logic [3:0]  r_dwe;
    logic        r_req_ready, r_resp_valid, r_resp_err;

    logic [3:0]  w_mask;
    logic [1:0]  w_size_m1;
    logic [7:0]  w_span;
    logic [32:0] w_last;
    logic        w_err;

    function automatic logic [31:0] f_extend(input logic [63:0] data, input logic [1:0] o,
                                             input logic [2:0] f3);
        logic [63:0] s;
        s = data >> {o, 3'b000};
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'b0, s[7:0]};
            3'b101:  return {16'b0, s[15:0]};
            default: return s[31:0];
        endcase
    endfunction

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   begin w_mask = 4'b0001; w_size_m1 = 2'd0; end
            2'b01:   begin w_mask = 4'b0011; w_size_m1 = 2'd1; end
            default: begin w_mask = 4'b1111; w_size_m1 = 2'd3; end
        endcase
        w_span = {4'b0000, w_mask} << req_addr[1:0];
        // 33-bit sum so an access touching the top of the address space cannot wrap past the check
        w_last = {1'b0, req_addr} + {31'b0, w_size_m1};
        w_err  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                 (w_last >= 33'(DMEM_BYTES)) || (req_store && req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        w_err  = w_err || (|w_span[7:4]);
`else
        w_err  = w_err;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_wdata      <= '0;
            r_lo         <= '0;
            r_funct3     <= '0;
            r_store      <= 1'b0;
            r_o          <= '0;
            r_span       <= '0;
            r_daddr      <= '0;
            r_dwdata     <= '0;
            r_dwe        <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: if (req_valid) begin
                    r_wdata     <= req_wdata;
                    r_funct3    <= req_funct3;
                    r_store     <= req_store;
                    r_o         <= req_addr[1:0];
                    r_span      <= w_span;
                    r_req_ready <= 1'b0;
                    if (w_err) begin
                        r_state      <= StResp;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= '0;
                    end else begin
                        r_state  <= StAcc0;
                        r_daddr  <= {req_addr[31:2], 2'b00};
                        r_dwe    <= req_store ? w_span[3:0] : 4'b0000;
                        r_dwdata <= req_store ? (req_wdata << {req_addr[1:0], 3'b000}) : '0;
                    end
                end
                StAcc0: begin
                    r_lo <= drdata;
                    if (|r_span[7:4]) begin
                        r_state  <= StAcc1;
                        r_daddr  <= r_daddr + 32'd4;
                        r_dwe    <= r_store ? r_span[7:4] : 4'b0000;
                        r_dwdata <= r_store ? (r_wdata >> (6'd32 - {1'b0, r_o, 3'b000})) : '0;
                    end else begin
                        r_state      <= StResp;
                        r_daddr      <= '0;
                        r_dwe        <= '0;
                        r_dwdata     <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_store ? '0 : f_extend({32'b0, drdata}, r_o, r_funct3);
                    end
                end
                StAcc1: begin
                    r_state      <= StResp;
                    r_daddr      <= '0;
                    r_dwe        <= '0;
                    r_dwdata     <= '0;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= r_store ? '0 : f_extend({drdata, r_lo}, r_o, r_funct3);
                end
                StResp: if (resp_ready) begin
                    r_state      <= StIdle;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Write enables drop the moment reset rises so no byte commits on a reset edge
    assign dwe        = r_dwe & {4{~reset}};
    assign daddr      = r_daddr;
    assign dwdata     = r_dwdata;
    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
endmodule

// File: tb/tb_lsu_split.sv
// Bench for lsu_split: byte-level reference model plus a per-cycle compare of writes and responses.
module tb_lsu_split;
    localparam int unsigned DMEM = 16384;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        req_store = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] daddr, dwdata, drdata;
    logic [3:0]  dwe;

    logic [7:0]  mem     [0:DMEM-1];
    logic [7:0]  ref_mem [0:DMEM-1];
    wr_t         exp_wr[$];
    wr_t         wr_log[$];
    logic [31:0] exp_rdata = '0;
    logic        exp_err = 1'b0;
    int          exp_lat = 0;
    int          checks = 0;
    int          failures = 0;

    lsu_split #(.DMEM_BYTES(DMEM)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_funct3(req_funct3), .req_store(req_store),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        drdata = {mem[{daddr[13:2], 2'd3}], mem[{daddr[13:2], 2'd2}],
                  mem[{daddr[13:2], 2'd1}], mem[{daddr[13:2], 2'd0}]};
    end

    // dmem: initial contents, then byte-lane writes on the clock edge
    initial begin
        for (int i = 0; i < DMEM; i++) mem[i] = 8'h00;
        mem[0] = 8'h01;
        mem[1] = 8'h80;
        forever begin
            @(posedge clk);
            for (int l = 0; l < 4; l++)
                if (dwe[l]) mem[{daddr[13:2], 2'(l)}] = dwdata[8*l +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: byte-addressed memory, access size and legality straight from the RV32I rules
    task automatic model_req(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                             input logic st);
        int          size;
        bit          legal, split;
        longint      last;
        logic [31:0] v, ba;
        wr_t         r;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        last  = longint'(a) + longint'(size) - 1;
        split = (int'(a[1:0]) + size) > 4;
        exp_err = !legal || (last >= longint'(DMEM)) || (st && f3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        if (split) exp_err = 1'b1;
`endif
        exp_lat   = exp_err ? 0 : (split ? 2 : 1);
        exp_rdata = '0;
        if (!exp_err && !st) begin
            v = '0;
            for (int i = 0; i < size; i++) v |= 32'(ref_mem[a + 32'(i)]) << (8 * i);
            if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
            if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
            exp_rdata = v;
        end
        if (!exp_err && st) begin
            for (int w = 0; w < 2; w++) begin
                r.addr = {a[31:2], 2'b00} + 32'(4 * w);
                r.be   = '0;
                r.data = '0;
                for (int i = 0; i < size; i++) begin
                    ba = a + 32'(i);
                    if ({ba[31:2], 2'b00} == r.addr) begin
                        r.be[ba[1:0]]          = 1'b1;
                        r.data[8*ba[1:0] +: 8] = wd[8*i +: 8];
                        ref_mem[ba]            = wd[8*i +: 8];
                    end
                end
                if (r.be != 4'b0) exp_wr.push_back(r);
            end
        end
    endtask

    // Every cycle: each dmem write must be the next one the model predicts; responses must match
    initial begin
        wr_t         e, o;
        logic [31:0] m;
        forever begin
            @(negedge clk);
            if (!reset && dwe != 4'b0) begin
                o.addr = daddr; o.be = dwe; o.data = dwdata;
                wr_log.push_back(o);
                chk("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    m = {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}};
                    chk("wr_addr", daddr, e.addr);
                    chk("wr_be", 32'(dwe), 32'(e.be));
                    chk("wr_data", dwdata & m, e.data);
                end
            end
            if (!reset && resp_valid) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err", 32'(resp_err), 32'(exp_err));
                chk("resp_ready_low", 32'(req_ready), 32'd0);
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                          input logic st, input int hold,
                          output logic [31:0] rd, output logic er);
        int n;
        model_req(a, wd, f3, st);
        wr_log.delete();
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = a; req_wdata = wd; req_funct3 = f3; req_store = st;
        resp_ready = (hold == 0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(exp_lat));
        rd = resp_rdata;
        er = resp_err;
        for (int k = 0; k < hold; k++) begin
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, rd);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("resp_drop", 32'(resp_valid), 32'd0);
        chk("back_idle", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        for (int i = 0; i < DMEM; i++) ref_mem[i] = 8'h00;
        ref_mem[0] = 8'h01;
        ref_mem[1] = 8'h80;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_dwe", 32'(dwe), 32'd0);
        chk("rst_daddr", daddr, 32'd0);
        chk("rst_dwdata", dwdata, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);

        do_req(32'h100, 32'hDEADBEEF, 3'b010, 1'b1, 0, rd, er);
        chk("sw_dwe_lit", 32'(wr_log[0].be), 32'hF);
        do_req(32'h100, 32'h0, 3'b010, 1'b0, 0, rd, er);
        chk("lw_lit", rd, 32'hDEADBEEF);

        do_req(32'h203, 32'h80, 3'b000, 1'b1, 0, rd, er);
        chk("sb_dwe_lit", 32'(wr_log[0].be), 32'h8);
        chk("sb_data_lit", 32'(wr_log[0].data[31:24]), 32'h80);
        do_req(32'h203, 32'h0, 3'b000, 1'b0, 0, rd, er);
        chk("lb_lit", rd, 32'hFFFFFF80);
        do_req(32'h203, 32'h0, 3'b100, 1'b0, 0, rd, er);
        chk("lbu_lit", rd, 32'h00000080);

        do_req(32'h102, 32'h11223344, 3'b010, 1'b1, 0, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("split_trap_err", 32'(er), 32'd1);
        chk("split_trap_nowr", 32'(wr_log.size()), 32'd0);
`else
        chk("split_nwr", 32'(wr_log.size()), 32'd2);
        chk("split_a0", wr_log[0].addr, 32'h100);
        chk("split_be0", 32'(wr_log[0].be), 32'hC);
        chk("split_d0", wr_log[0].data, 32'h33440000);
        chk("split_a1", wr_log[1].addr, 32'h104);
        chk("split_be1", 32'(wr_log[1].be), 32'h3);
        chk("split_d1", wr_log[1].data, 32'h00001122);
`endif
        do_req(32'h102, 32'h0, 3'b010, 1'b0, 0, rd, er);
`ifndef LSU_MISALIGN_TRAP_EN
        chk("split_lw_lit", rd, 32'h11223344);
`endif
        do_req(32'h103, 32'h0, 3'b001, 1'b0, 0, rd, er);

        do_req(32'h0, 32'h0, 3'b001, 1'b0, 5, rd, er);
        chk("lh_bp_lit", rd, 32'hFFFF8001);

        do_req(32'h100, 32'h0, 3'b011, 1'b0, 0, rd, er);
        chk("f3_illegal_lit", 32'(er), 32'd1);
        do_req(32'h3FFE, 32'h0, 3'b010, 1'b0, 0, rd, er);
        chk("oob_lw_lit", 32'(er), 32'd1);
        do_req(32'h3FFC, 32'h12345678, 3'b010, 1'b1, 0, rd, er);
        do_req(32'h3FFE, 32'h0, 3'b101, 1'b0, 0, rd, er);
        chk("top_lhu_lit", rd, 32'h00001234);
        do_req(32'h3FFE, 32'h5555, 3'b010, 1'b1, 0, rd, er);
        chk("oob_sw_nowr", 32'(wr_log.size()), 32'd0);
        do_req(32'h4000, 32'h0, 3'b000, 1'b0, 0, rd, er);
        do_req(32'h200, 32'h0, 3'b101, 1'b1, 0, rd, er);
        chk("sh_unsigned_err", 32'(er), 32'd1);

`ifdef LSU_MISALIGN_TRAP_EN
        do_req(32'h0FE, 32'hAABBCCDD, 3'b010, 1'b1, 0, rd, er);
`else
        // Reset lands in the second half of a split store: only the first word's bytes survive
        model_req(32'h0FE, 32'hAABBCCDD, 3'b010, 1'b1);
        ref_mem[32'h100] = 8'hEF;
        ref_mem[32'h101] = 8'hBE;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0FE; req_wdata = 32'hAABBCCDD;
        req_funct3 = 3'b010; req_store = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_acc1_dwe", 32'(dwe), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        exp_wr.delete();
        @(negedge clk);
        chk("rst_acc1_ready", 32'(req_ready), 32'd1);
        chk("rst_acc1_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem100", 32'(mem[32'h100]), 32'hEF);
        chk("rst_mem101", 32'(mem[32'h101]), 32'hBE);
        do_req(32'h0FC, 32'h0, 3'b010, 1'b0, 0, rd, er);
        chk("rst_partial_lit", rd, 32'hCCDD0000);
`endif
        do_req(32'h100, 32'h0, 3'b001, 1'b0, 0, rd, er);
        chk("lh_after_lit", rd, 32'hFFFFBEEF);
        chk("wr_all_seen", 32'(exp_wr.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/lsu_split.md
Name: lsu_split

Overview:
- Load/store unit between the CPU execute stage and the 4-bank byte-lane data memory (dmem).
- Accepts one RV32I load/store request per transaction over a valid/ready handshake and drives dmem's daddr/dwdata/dwe.
- Aligns and sign/zero-extends read data, and splits word-crossing (misaligned) accesses into two sequential word accesses.
- dmem read is combinational; dmem write commits on posedge clk.

Parameters:
- DMEM_BYTES, 16384, size of the data memory in bytes. Any byte of an access at or above this is out of range.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_store  in  1  1 = store, 0 = load
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request rejected, no memory side effect
- daddr  out  32  to dmem, word aligned (bits[1:0] = 0)
- dwdata  out  32  to dmem, lane-shifted write data
- dwe  out  4  to dmem, per-byte write enables
- drdata  in  32  from dmem, combinational read data

Behaviour:
- States: IDLE, ACC0, ACC1, RESP. Reset (synchronous) forces IDLE, clears the capture registers, and clears resp_err and resp_rdata to 0.
- Reset output values: req_ready = 1, resp_valid = 0, dwe = 0, daddr = 0, dwdata = 0.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch addr, wdata, funct3 and store; compute o = addr[1:0] and mask (B 0001, H 0011, W 1111).
  - Illegal funct3 (011, 110, 111), any byte >= DMEM_BYTES, or a store with funct3 100/101: go to RESP with err = 1. No dmem access.
  - Otherwise go to ACC0.
- ACC0:
  - daddr = {addr[31:2], 2'b00}.
  - Store: dwe = (mask << o)[3:0], dwdata = wdata << 8*o.
  - Load: dwe = 0; capture drdata into lo.
  - If (mask << o)[7:4] != 0, go to ACC1; else go to RESP.
- ACC1:
  - daddr = ACC0 address + 4.
  - Store: dwe = (mask << o)[7:4], dwdata = wdata >> 8*(4 - o).
  - Load: capture drdata into hi.
  - Go to RESP.
- RESP:
  - resp_valid = 1.
  - Load rdata = ({hi, lo} >> 8*o), truncated to the access size, then sign-extended (B/H) or zero-extended (BU/HU/W).
  - Hold all response outputs stable until resp_ready; on resp_valid && resp_ready go to IDLE.
  - No new request is accepted in the same cycle (req_ready = 0 outside IDLE).
- Latency from the accept edge to resp_valid high:
  - aligned access: 1 cycle (ACC0, then RESP);
  - split access: 2 cycles;
  - error: 0 cycles (RESP is the next state).
- dwe is 0 in IDLE and RESP, and is gated by !reset combinationally. A write never commits on an edge where reset = 1, even mid-ACC0/ACC1.
  - Consequence: reset during ACC1 of a split store leaves only the ACC0 bytes written. This partial write is accepted behaviour.
- Address wrap: the ACC1 address uses 32-bit arithmetic, but the range check rejects crossings at DMEM_BYTES before any write.
- daddr and dwdata outside ACC0/ACC1 are don't-care. They are driven to 0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: any access with (mask << o)[7:4] != 0 takes IDLE -> RESP with resp_err = 1. No dmem access; ACC1 is unreachable.
- Not defined: such accesses are split as described above; resp_err only reports illegal funct3, out-of-range and store-unsigned cases.

Test Plan:
- Aligned SW 0x100 = 0xDEADBEEF, then LW 0x100:
  - SW: dwe = 1111 in ACC0.
  - LW: rdata = 0xDEADBEEF, resp_valid 1 cycle after accept.
- SB 0x203 = 0x80, then LB 0x203 and LBU 0x203:
  - SB: dwe = 1000, dwdata[31:24] = 0x80.
  - LB: 0xFFFFFF80. LBU: 0x00000080.
- Split SW 0x102 = 0x11223344:
  - ACC0: daddr 0x100, dwe 1100, dwdata 0x33440000.
  - ACC1: daddr 0x104, dwe 0011, dwdata 0x00001122.
  - LW 0x102 returns 0x11223344 after 2 cycles. With LSU_MISALIGN_TRAP_EN: resp_err = 1 and dwe stays 0000.
- Back-pressure: hold resp_ready = 0 for 5 cycles after an LH 0x0 (mem 0x8001) -> rdata 0xFFFF8001 stable throughout, req_ready = 0; IDLE after resp_ready.
- Errors:
  - funct3 = 011 -> resp_err = 1.
  - LW 0x3FFE (DMEM_BYTES = 16384) -> resp_err = 1, no dmem write.
- Reset during ACC1 of split SW 0x0FE: assert reset -> dwe = 0 that cycle; bytes at 0x100/0x101 unchanged; req_ready = 1 next cycle.
